// File: rtl/bj_pkg.sv
// Shared blackjack definitions: action codes used by the button queue and the game FSM.
package bj_pkg;
  localparam int ACT_W = 2;

  localparam logic [ACT_W-1:0] ACT_NONE  = 2'd0;
  localparam logic [ACT_W-1:0] ACT_HIT   = 2'd1;
  localparam logic [ACT_W-1:0] ACT_STAND = 2'd2;
  localparam logic [ACT_W-1:0] ACT_DEAL  = 2'd3;

  // Fixed priority DEAL > STAND > HIT.
  function automatic logic [ACT_W-1:0] prio_action(input logic hit, input logic stand,
                                                   input logic deal);
    if (deal)       return ACT_DEAL;
    else if (stand) return ACT_STAND;
    else if (hit)   return ACT_HIT;
    return ACT_NONE;
  endfunction
endpackage

// File: rtl/sync_rise_detect.sv
// 2-FF synchroniser followed by a rising-edge register; emits a one-cycle rise pulse.
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic [1:0] sync_q, sync_d;
  logic       edge_q, edge_d;
  logic [2:0] vld_pipe_q, vld_pipe_d;

  always_comb begin
    sync_d     = {sync_q[0], din};
    edge_d     = sync_q[1];
    vld_pipe_d = {vld_pipe_q[1:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      edge_q     <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      sync_q     <= sync_d;
      edge_q     <= edge_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Edges are only trusted once the edge register has loaded a real synchroniser
  // value, so a button held through reset release never looks like a press.
  assign rise = sync_q[1] & ~edge_q & vld_pipe_q[2];
endmodule

// File: rtl/button_action_queue.sv
// Turns debounced hit/stand/deal levels into prioritised, rate-limited action
// events and buffers them in a small FIFO popped by the game FSM.
module button_action_queue
  import bj_pkg::*;
#(
  parameter int          DEPTH          = 4,
  parameter logic [25:0] LOCKOUT_CYCLES = 26'd12_500_000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       hit_pressed,
  input  logic                       stand_pressed,
  input  logic                       deal_pressed,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       action_ready,
  output logic                       action_valid,
  output logic [ACT_W-1:0]           action_code,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       queue_full,
  output logic                       dropped
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [2:0] btn, rise;
  assign btn = {deal_pressed, stand_pressed, hit_pressed};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    sync_rise_detect u_sync (
      .clk   (CLOCK_50),
      .reset (reset),
      .din   (btn[i]),
      .rise  (rise[i])
    );
  end

  logic [ACT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic [25:0]      lock_q, lock_d;
  logic             dropped_q, dropped_d;

  logic [ACT_W-1:0] cand;
  logic             multi, accept, push, pop;

  always_comb begin
    cand   = prio_action(rise[0], rise[1], rise[2]);
    multi  = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
    accept = (cand != ACT_NONE) && enable && (lock_q == '0) && !flush;
    // A full queue rejects the push even if the head is popped this cycle.
    push   = accept && !full_q;
    pop    = (count_q != '0) && action_ready && !flush;

    lock_d = lock_q;
    if (accept)              lock_d = LOCKOUT_CYCLES - 26'd1;
    else if (lock_q != '0)   lock_d = lock_q - 26'd1;

    dropped_d = multi | (accept & full_q);

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + AW'(push);
      rptr_d  = rptr_q + AW'(pop);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      lock_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      lock_q    <= lock_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wptr_q] <= cand;
  end

  assign action_valid = (count_q != '0);
  assign action_code  = action_valid ? mem_q[rptr_q] : ACT_NONE;
  assign queue_count  = count_q;
  assign queue_full   = full_q;
  assign dropped      = dropped_q;
endmodule

// File: tb/tb_button_action_queue.sv
// Directed scenarios plus random stimulus, every cycle compared against a
// queue-based reference model of the action queue.
module tb_button_action_queue;
  localparam int DEPTH = 4;
  localparam int L     = 150;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       hit_pressed = 1'b0, stand_pressed = 1'b0, deal_pressed = 1'b0;
  logic       enable = 1'b1, flush = 1'b0, action_ready = 1'b0;
  logic       action_valid;
  logic [1:0] action_code;
  logic [2:0] queue_count;
  logic       queue_full;
  logic       dropped;

  button_action_queue #(.DEPTH(DEPTH), .LOCKOUT_CYCLES(26'd150)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .hit_pressed   (hit_pressed),
    .stand_pressed (stand_pressed),
    .deal_pressed  (deal_pressed),
    .enable        (enable),
    .flush         (flush),
    .action_ready  (action_ready),
    .action_valid  (action_valid),
    .action_code   (action_code),
    .queue_count   (queue_count),
    .queue_full    (queue_full),
    .dropped       (dropped)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: button levels as seen at each edge since reset, a queue of
  // codes, and the edge index of the last accepted press.
  bit [2:0]   hist[$];
  logic [1:0] mq[$];
  longint     n_edge;
  longint     last_acc;
  bit         acc_ever;
  bit         e_drop;
  bit [2:0]   r;
  int         nr;
  logic [1:0] cand;
  bit         acc, was_full;

  always @(posedge CLOCK_50) begin
    if (reset) begin
      hist.delete();
      mq.delete();
      n_edge   = 0;
      acc_ever = 0;
      e_drop   = 0;
    end else begin
      hist.push_back({deal_pressed, stand_pressed, hit_pressed});
      if (hist.size() > 4) void'(hist.pop_front());
      // A press sampled at edge n-2 (and low at n-3) is acted on at edge n.
      r = (hist.size() == 4) ? (hist[1] & ~hist[0]) : 3'b000;
      nr = int'(r[0]) + int'(r[1]) + int'(r[2]);
      cand = r[2] ? 2'd3 : r[1] ? 2'd2 : r[0] ? 2'd1 : 2'd0;
      acc = (cand != 0) && enable && !flush && (!acc_ever || (n_edge - last_acc) >= L);
      was_full = (mq.size() == DEPTH);
      e_drop = (nr > 1) || (acc && was_full);
      if (flush) mq.delete();
      else begin
        if (mq.size() != 0 && action_ready) void'(mq.pop_front());
        if (acc && !was_full) mq.push_back(cand);
      end
      if (acc) begin
        acc_ever = 1;
        last_acc = n_edge;
      end
      n_edge++;
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("valid",   int'(action_valid), int'(mq.size() != 0));
      chk("code",    int'(action_code),  (mq.size() != 0) ? int'(mq[0]) : 0);
      chk("count",   int'(queue_count),  mq.size());
      chk("full",    int'(queue_full),   int'(mq.size() == DEPTH));
      chk("dropped", int'(dropped),      int'(e_drop));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic set_btn(input bit [2:0] m);
    {deal_pressed, stand_pressed, hit_pressed} = m;
  endtask

  // Press, release, then wait out the lockout.
  task automatic press(input bit [2:0] m);
    set_btn(m);
    tick(5);
    set_btn(3'b000);
    tick(L + 10);
  endtask

  int rdy_lvl;

  initial begin
    // Button held high through reset release must not become a press.
    hit_pressed = 1'b1;
    tick(4);
    chk_en = 1;
    reset = 1'b0;
    tick(10);
    chk("hold_count", int'(queue_count), 0);
    chk("hold_valid", int'(action_valid), 0);
    chk("hold_code", int'(action_code), 0);
    hit_pressed = 1'b0;
    tick(5);

    // Stand press latency, then a re-press inside the lockout window.
    stand_pressed = 1'b1;
    tick(2);
    chk("lat_early", int'(action_valid), 0);
    tick(1);
    chk("lat_valid", int'(action_valid), 1);
    chk("lat_code", int'(action_code), 2);
    chk("lat_count", int'(queue_count), 1);
    tick(5);
    stand_pressed = 1'b0;
    tick(95);
    stand_pressed = 1'b1;
    tick(10);
    chk("lockout_count", int'(queue_count), 1);
    stand_pressed = 1'b0;
    tick(L + 10);

    // Simultaneous hit and deal: deal wins, hit is dropped.
    flush = 1'b1; tick(1); flush = 1'b0;
    set_btn(3'b101);
    tick(3);
    chk("arb_code", int'(action_code), 3);
    chk("arb_drop", int'(dropped), 1);
    chk("arb_count", int'(queue_count), 1);
    tick(1);
    chk("arb_drop_end", int'(dropped), 0);
    set_btn(3'b000);
    tick(L + 10);

    // Fill to full, overflow drop, then drain in order.
    flush = 1'b1; tick(1); flush = 1'b0;
    press(3'b001); press(3'b010); press(3'b100); press(3'b001);
    chk("fill_full", int'(queue_full), 1);
    set_btn(3'b010);
    tick(3);
    chk("ovf_drop", int'(dropped), 1);
    chk("ovf_count", int'(queue_count), 4);
    set_btn(3'b000);
    tick(L + 10);
    action_ready = 1'b1;
    tick(1);
    chk("drain_head", int'(action_code), 2);
    tick(3);
    action_ready = 1'b0;
    chk("drain_count", int'(queue_count), 0);

    // Full queue: pop and rejected push in the same cycle.
    press(3'b100); press(3'b010); press(3'b001); press(3'b100);
    hit_pressed = 1'b1;
    tick(2);
    action_ready = 1'b1;
    tick(1);
    action_ready = 1'b0;
    chk("fullpop_count", int'(queue_count), 3);
    chk("fullpop_drop", int'(dropped), 1);
    hit_pressed = 1'b0;
    tick(L + 10);

    // Disabled press, then flush with two entries.
    flush = 1'b1; tick(1); flush = 1'b0;
    enable = 1'b0;
    set_btn(3'b001);
    tick(6);
    chk("dis_count", int'(queue_count), 0);
    chk("dis_drop", int'(dropped), 0);
    set_btn(3'b000);
    enable = 1'b1;
    tick(5);
    press(3'b010); press(3'b100);
    chk("pre_flush_count", int'(queue_count), 2);
    flush = 1'b1; tick(1); flush = 1'b0;
    chk("flush_count", int'(queue_count), 0);
    chk("flush_valid", int'(action_valid), 0);

    // Random traffic; the per-cycle model comparison does the checking.
    for (int blk = 0; blk < 12; blk++) begin
      rdy_lvl = $urandom_range(0, 8);
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 39) == 0) hit_pressed   = ~hit_pressed;
        if ($urandom_range(0, 39) == 0) stand_pressed = ~stand_pressed;
        if ($urandom_range(0, 39) == 0) deal_pressed  = ~deal_pressed;
        action_ready = ($urandom_range(0, 15) < rdy_lvl);
        enable       = ($urandom_range(0, 15) != 0);
        flush        = ($urandom_range(0, 299) == 0);
        reset        = ($urandom_range(0, 1999) == 0);
        tick(1);
      end
    end
    reset = 1'b0;
    flush = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
